// File: rtl/led_pattern_pkg.sv
// Shared definitions for the multi-channel LED pattern generator:
// channel modes, PWM width and the duty ceiling of the breathing ramp.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;

  localparam int PWM_W = 8;
  localparam logic [PWM_W-1:0] DUTY_MAX = 8'd255;

  // Only the animated modes consume ticks; OFF and ON keep their counters at zero.
  function automatic logic mode_is_active(input led_mode_e mode);
    return (mode == MODE_BLINK) || (mode == MODE_BREATHE);
  endfunction

endpackage

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: configuration, tick divider and BLINK/BREATHE pattern state.
// Produces the logical (un-inverted) lit level from its own state and the PWM phase.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  input  logic             we_i,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             lit_o
);

  led_mode_e        mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] ev_cnt_q, ev_cnt_d;
  logic             lit_q, lit_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             dir_q, dir_d;
  logic             event_s;

  // Next-state: a write restarts the channel and swallows a coincident tick.
  always_comb begin
    mode_d   = mode_q;
    div_d    = div_q;
    ev_cnt_d = ev_cnt_q;
    lit_d    = lit_q;
    duty_d   = duty_q;
    dir_d    = dir_q;
    event_s  = 1'b0;
    if (we_i) begin
      mode_d   = led_mode_e'(mode_i);
      div_d    = div_i;
      ev_cnt_d = '0;
      lit_d    = 1'b0;
      duty_d   = '0;
      dir_d    = 1'b0;
    end else if (tick_i && mode_is_active(mode_q)) begin
      if (ev_cnt_q < div_q) begin
        ev_cnt_d = ev_cnt_q + DIV_W'(1);
      end else begin
        ev_cnt_d = '0;
        event_s  = 1'b1;
      end
    end else begin
      event_s = 1'b0;
    end

    // The ramp turns around in the same event that reaches either end.
    if (event_s) begin
      case (mode_q)
        MODE_BLINK: lit_d = ~lit_q;
        MODE_BREATHE: begin
          if (dir_q == 1'b0) begin
            duty_d = duty_q + 8'd1;
            dir_d  = (duty_d == DUTY_MAX);
          end else begin
            duty_d = duty_q - 8'd1;
            dir_d  = (duty_d != 8'd0);
          end
        end
        default: lit_d = lit_q;
      endcase
    end else begin
      lit_d = lit_d;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q   <= MODE_OFF;
      div_q    <= '0;
      ev_cnt_q <= '0;
      lit_q    <= 1'b0;
      duty_q   <= '0;
      dir_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      div_q    <= div_d;
      ev_cnt_q <= ev_cnt_d;
      lit_q    <= lit_d;
      duty_q   <= duty_d;
      dir_q    <= dir_d;
    end
  end

  // Logical lit level; the top registers it onto the pin.
  always_comb begin
    case (mode_q)
      MODE_OFF:     lit_o = 1'b0;
      MODE_ON:      lit_o = 1'b1;
      MODE_BLINK:   lit_o = lit_q;
      MODE_BREATHE: lit_o = (pwm_cnt_i < duty_q);
      default:      lit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator top: shared prescaler, PWM phase counter,
// config write decode and the registered LED pins.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int TICK_DIV   = 13_499,
  parameter int DIV_W      = 16,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              tick,
  output logic [NUM_CH-1:0] led
);

  localparam int PRE_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(TICK_DIV);

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              tick_q;
  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [NUM_CH-1:0] led_q;
  logic [NUM_CH-1:0] lit_s;
  logic [NUM_CH-1:0] we_s;

  // Prescaler and PWM phase next-state.
  always_comb begin
    if (pre_cnt_q == PRE_TC) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
    pwm_cnt_d = pwm_cnt_q + 8'd1;
  end

  // tick is registered from the next prescaler value so it mirrors pre_cnt == TICK_DIV.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
      pwm_cnt_q <= '0;
      led_q     <= {NUM_CH{ACTIVE_LOW}};
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= (pre_cnt_d == PRE_TC);
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= lit_s ^ {NUM_CH{ACTIVE_LOW}};
    end
  end

  // Out-of-range channel numbers match no decode and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign we_s[i] = cfg_we && (cfg_ch == CH_W'(i));

    led_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk_i    (sys_clk),
      .rst_i    (sys_reset),
      .tick_i   (tick_q),
      .pwm_cnt_i(pwm_cnt_q),
      .we_i     (we_s[i]),
      .mode_i   (cfg_mode),
      .div_i    (cfg_div),
      .lit_o    (lit_s[i])
    );
  end

  assign tick = tick_q;
  assign led  = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios then random config traffic,
// each cycle compared against a tick/event-count model of the LED patterns.
module tb_led_pattern_gen;

  localparam int NUM_CH = 3;
  localparam int TICK_DIV = 3;
  localparam int DIV_W = 16;
  localparam int CH_W = 2;
  localparam logic ACTIVE_LOW = 1'b1;

  logic              sys_clk = 1'b0;
  logic              sys_reset;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [DIV_W-1:0]  cfg_div;
  logic              tick;
  logic [NUM_CH-1:0] led;

  led_pattern_gen #(
    .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .DIV_W(DIV_W), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_div(cfg_div), .tick(tick), .led(led)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: per channel, its mode, divisor and ticks counted since its last write.
  int m_mode [NUM_CH];
  int m_div  [NUM_CH];
  int m_ticks[NUM_CH];
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Lit level from event count: BLINK is event parity, BREATHE is a 510-event triangle.
  function automatic bit model_lit(input int ch);
    int ev;
    int e;
    int duty;
    ev = m_ticks[ch] / (m_div[ch] + 1);
    e = ev % 510;
    duty = (e <= 255) ? e : 510 - e;
    case (m_mode[ch])
      0: return 1'b0;
      1: return 1'b1;
      2: return (ev % 2) == 1;
      default: return (cyc % 256) < duty;
    endcase
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = 0;
      m_div[c] = 0;
      m_ticks[c] = 0;
    end
  endtask

  // One clock: predict, advance the model with the sampled inputs, then check outputs.
  task automatic step(input string tag);
    logic [NUM_CH-1:0] exp_led;
    logic exp_tick;
    bit tk;
    tk = (cyc % (TICK_DIV + 1)) == TICK_DIV;
    for (int c = 0; c < NUM_CH; c++) exp_led[c] = model_lit(c) ^ ACTIVE_LOW;
    @(posedge sys_clk);
    if (sys_reset) begin
      model_clear();
      cyc = 0;
      exp_led = {NUM_CH{ACTIVE_LOW}};
      exp_tick = 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_we && int'(cfg_ch) == c) begin
          m_mode[c] = int'(cfg_mode);
          m_div[c] = int'(cfg_div);
          m_ticks[c] = 0;
        end else if (tk && m_mode[c] >= 2) begin
          m_ticks[c]++;
        end
      end
      cyc++;
      exp_tick = (cyc % (TICK_DIV + 1)) == TICK_DIV;
    end
    #1;
    check_val($sformatf("%s_led", tag), 32'(led), 32'(exp_led));
    check_val($sformatf("%s_tick", tag), 32'(tick), 32'(exp_tick));
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic write_cfg(input int ch, input int mode, input int div, input string tag);
    cfg_we = 1'b1;
    cfg_ch = CH_W'(ch);
    cfg_mode = 2'(mode);
    cfg_div = DIV_W'(div);
    step(tag);
    cfg_we = 1'b0;
  endtask

  initial begin
    int first_tick;
    model_clear();
    sys_reset = 1'b1;
    cfg_we = 1'b1;
    cfg_ch = 2'd1;
    cfg_mode = 2'd1;
    cfg_div = 16'd0;
    run(2, "reset");
    check_val("reset_led_dark", 32'(led), 32'h7);
    check_val("reset_tick_low", 32'(tick), 32'h0);
    sys_reset = 1'b0;
    cfg_we = 1'b0;

    first_tick = -1;
    for (int i = 0; i < 12; i++) begin
      step("boot");
      if (tick === 1'b1 && first_tick < 0) first_tick = cyc;
    end
    check_val("first_tick_cycle", 32'(first_tick), 32'd3);

    write_cfg(1, 1, 0, "on_wr");
    check_val("on_latency_edge1", 32'(led[1]), 32'h1);
    step("on");
    check_val("on_latency_edge2", 32'(led[1]), 32'h0);
    run(6, "on");

    write_cfg(0, 2, 1, "blink_wr");
    run(40, "blink");

    write_cfg(2, 3, 0, "breathe_wr");
    run(1100, "breathe");

    write_cfg(1, 2, 0, "ch1_blink_wr");
    run(9, "ch1_blink");
    for (int i = 0; i < 4 && (cyc % (TICK_DIV + 1)) != TICK_DIV; i++) step("align");
    check_val("collide_aligned", 32'(cyc % (TICK_DIV + 1)), 32'(TICK_DIV));
    write_cfg(0, 2, 0, "collide_wr");
    run(12, "collide");

    write_cfg(3, 1, 0, "illegal_wr");
    run(6, "illegal");

    sys_reset = 1'b1;
    step("mid_reset");
    check_val("mid_reset_led_dark", 32'(led), 32'h7);
    sys_reset = 1'b0;
    run(20, "post_reset");

    for (int i = 0; i < 3000; i++) begin
      sys_reset = ($urandom_range(0, 299) == 0);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_ch = CH_W'($urandom_range(0, 3));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_div = DIV_W'($urandom_range(0, 3));
      step("rand");
    end
    sys_reset = 1'b0;
    cfg_we = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
